// File: rtl/seg_scan_mux.sv
// Four-digit multiplexed seven-segment scanner with a tear-free double buffer,
// per-slot blanking and per-digit raw/hex selection. All outputs are registered.
module seg_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [7:0] i_d0,
    input  logic [7:0] i_d1,
    input  logic [7:0] i_d2,
    input  logic [7:0] i_d3,
    input  logic [3:0] i_raw_mask,
    input  logic       i_load,
    input  logic       i_blank,
    output logic [6:0] o_seg,
    output logic [3:0] o_an,
    output logic       o_dp,
    output logic       o_frame_sync
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] r_c;
    logic [1:0]    r_i;
    logic [7:0]    r_pend_d [4];
    logic [3:0]    r_pend_mask;
    logic          r_pend_valid;
    logic [7:0]    r_act_d [4];
    logic [3:0]    r_act_mask;
    logic [6:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_dp;
    logic          r_frame_sync;

    logic          w_boundary;
    logic          w_xfer;
    logic [7:0]    w_digit;
    logic          w_raw;
    logic          w_dark;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Digit selection sees the pending buffer on a transferring boundary so frame start is already new.
    always_comb begin
        w_boundary = (r_c == {CW{1'b0}}) && (r_i == 2'd0);
        w_xfer     = w_boundary && r_pend_valid;
        if (w_xfer) begin
            w_digit = r_pend_d[r_i];
            w_raw   = r_pend_mask[r_i];
        end else begin
            w_digit = r_act_d[r_i];
            w_raw   = r_act_mask[r_i];
        end
        w_dark = i_blank || (r_c < C_BLANK);
    end

    // Slot counter and digit index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_c <= {CW{1'b0}};
            r_i <= 2'd0;
        end else if (r_c == C_LAST) begin
            r_c <= {CW{1'b0}};
            r_i <= r_i + 2'd1;
        end else begin
            r_c <= r_c + {{(CW-1){1'b0}}, 1'b1};
            r_i <= r_i;
        end
    end

    // Pending/active buffers; a load on the boundary cycle stays pending for the next frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < 4; k++) begin
                r_pend_d[k] <= 8'h00;
                r_act_d[k]  <= 8'h00;
            end
            r_pend_mask  <= 4'h0;
            r_act_mask   <= 4'h0;
            r_pend_valid <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_act_d    <= r_pend_d;
                r_act_mask <= r_pend_mask;
            end else begin
                r_act_d    <= r_act_d;
                r_act_mask <= r_act_mask;
            end
            if (i_load) begin
                r_pend_d[0]  <= i_d0;
                r_pend_d[1]  <= i_d1;
                r_pend_d[2]  <= i_d2;
                r_pend_d[3]  <= i_d3;
                r_pend_mask  <= i_raw_mask;
                r_pend_valid <= 1'b1;
            end else if (w_xfer) begin
                r_pend_valid <= 1'b0;
            end else begin
                r_pend_valid <= r_pend_valid;
            end
        end
    end

    // Registered pin drivers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_seg        <= 7'h7F;
            r_an         <= 4'hF;
            r_dp         <= 1'b1;
            r_frame_sync <= 1'b0;
        end else begin
            r_frame_sync <= w_boundary;
            if (w_dark) begin
                r_seg <= 7'h7F;
                r_an  <= 4'hF;
                r_dp  <= 1'b1;
            end else begin
                r_an <= ~(4'b0001 << r_i);
                if (w_raw) begin
                    r_seg <= w_digit[6:0];
                    r_dp  <= w_digit[7];
                end else begin
                    r_seg <= hex_to_seg(w_digit[3:0]);
                    r_dp  <= 1'b1;
                end
            end
        end
    end

    assign o_seg        = r_seg;
    assign o_an         = r_an;
    assign o_dp         = r_dp;
    assign o_frame_sync = r_frame_sync;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: a frame-position model pushes the expected
// pin vector for every driven cycle; it is popped and compared after the edge.
module tb_seg_scan_mux;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;
    localparam logic [6:0] HEX_TBL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic       clk = 1'b0;
    logic       reset, load, blank;
    logic [7:0] d0, d1, d2, d3;
    logic [3:0] raw_mask;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp, frame_sync;

    int n_cmp = 0;
    int n_err = 0;
    int t = 0;
    string phase = "reset";
    logic [12:0] exp_q [$];
    logic [7:0]  m_pend [4];
    logic [7:0]  m_act [4];
    logic [3:0]  m_pmask, m_amask;
    bit          m_pv;

    seg_scan_mux #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .i_clk(clk), .i_reset(reset), .i_d0(d0), .i_d1(d1), .i_d2(d2), .i_d3(d3),
        .i_raw_mask(raw_mask), .i_load(load), .i_blank(blank),
        .o_seg(seg), .o_an(an), .o_dp(dp), .o_frame_sync(frame_sync)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [12:0] obs, input logic [12:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s t=%0d got=%h expected=%h", tag, t, obs, expv);
        end
    endtask

    // One cycle: derive expected pins from frame position, push, clock, pop and compare.
    task automatic tick();
        logic [12:0] e;
        logic [7:0]  dv;
        logic [3:0]  an_e;
        logic        rw, bnd;
        int          pos, c, i;
        if (reset) begin
            e = {1'b0, 4'hF, 7'h7F, 1'b1};
            t = 0;
            for (int k = 0; k < 4; k++) begin
                m_pend[k] = 8'h00;
                m_act[k]  = 8'h00;
            end
            m_pmask = 4'h0;
            m_amask = 4'h0;
            m_pv    = 1'b0;
        end else begin
            pos = t % FRAME;
            c   = pos % RD;
            i   = pos / RD;
            bnd = (pos == 0);
            if (bnd && m_pv) begin
                m_act   = m_pend;
                m_amask = m_pmask;
                m_pv    = 1'b0;
            end
            dv   = m_act[i];
            rw   = m_amask[i];
            an_e = ~(4'b0001 << i);
            if (blank || c < BC)
                e = {bnd, 4'hF, 7'h7F, 1'b1};
            else if (rw)
                e = {bnd, an_e, dv[6:0], dv[7]};
            else
                e = {bnd, an_e, HEX_TBL[dv[3:0]], 1'b1};
            if (load) begin
                m_pend  = '{d0, d1, d2, d3};
                m_pmask = raw_mask;
                m_pv    = 1'b1;
            end
            t++;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_eq(phase, {frame_sync, an, seg, dp}, exp_q.pop_front());
    endtask

    task automatic run_to(input int p);
        int n = 0;
        do begin
            tick();
            n++;
        end while ((t % FRAME) != p && n < 2 * FRAME);
        if ((t % FRAME) != p) check_eq("run_to_bound", 13'd1, 13'd0);
    endtask

    task automatic load_vals(input logic [7:0] a, b, c, d, input logic [3:0] m);
        d0 = a; d1 = b; d2 = c; d3 = d; raw_mask = m; load = 1'b1;
        tick();
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b1; load = 1'b1; blank = 1'b0;
        d0 = 8'h08; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00; raw_mask = 4'h0;
        for (int k = 0; k < 3; k++) tick();
        check_eq("rst_pins", {frame_sync, an, seg, dp}, {1'b0, 4'hF, 7'h7F, 1'b1});
        load = 1'b0;
        reset = 1'b0;
        phase = "after_rst";
        run_to(4);
        check_eq("first_frame_d0", {6'd0, an, seg}, {6'd0, 4'hE, 7'h40});
        run_to(0);

        phase = "hex_scan";
        load_vals(8'h00, 8'h01, 8'h0A, 8'h0F, 4'h0);
        run_to(0);
        run_to(4);
        check_eq("hex_d0", {6'd0, an, seg}, {6'd0, 4'hE, 7'h40});
        run_to(20);
        check_eq("hex_d2", {6'd0, an, seg}, {6'd0, 4'hB, 7'h08});
        run_to(0);

        phase = "raw";
        load_vals(8'hF6, 8'h76, 8'h00, 8'h00, 4'h1);
        run_to(0);
        run_to(4);
        check_eq("raw_d0", {5'd0, an, seg, dp}, {5'd0, 4'hE, 7'h76, 1'b1});
        run_to(12);
        check_eq("hex6_d1", {5'd0, an, seg, dp}, {5'd0, 4'hD, 7'h02, 1'b1});
        run_to(0);

        phase = "tear_free";
        run_to(11);
        load_vals(8'h03, 8'h04, 8'h05, 8'h0E, 4'h0);
        run_to(24);
        check_eq("old_d2_kept", {6'd0, an, seg}, {6'd0, 4'hB, 7'h40});
        run_to(1);
        check_eq("sync_at_swap", {12'd0, frame_sync}, {12'd0, 1'b1});
        run_to(4);
        check_eq("new_d0", {6'd0, an, seg}, {6'd0, 4'hE, 7'h30});
        run_to(0);

        phase = "boundary_load";
        run_to(10);
        load_vals(8'h01, 8'h02, 8'h03, 8'h04, 4'h0);
        run_to(0);
        load_vals(8'h09, 8'h08, 8'h07, 8'h06, 4'h0);
        run_to(4);
        check_eq("frame_shows_a", {6'd0, an, seg}, {6'd0, 4'hE, 7'h79});
        run_to(0);
        run_to(4);
        check_eq("next_shows_b", {6'd0, an, seg}, {6'd0, 4'hE, 7'h10});
        run_to(0);

        phase = "blank";
        run_to(5);
        blank = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check_eq("blank_an", {9'd0, an}, {9'd0, 4'hF});
        blank = 1'b0;
        run_to(0);
        run_to(1);
        check_eq("blank_sync", {12'd0, frame_sync}, {12'd0, 1'b1});

        phase = "mid_reset";
        run_to(20);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run_to(4);
        check_eq("post_rst_d0", {6'd0, an, seg}, {6'd0, 4'hE, 7'h40});
        run_to(0);
        run_to(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
